// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//   ID/EX pipeline register with built-in load-use hazard detection.
//   Captures the decoded instruction and its register-file operands at the
//   ID/EX boundary and presents them to EX and to the forwarding unit.
//
//   When the instruction in ID reads the destination of a load that is
//   currently in EX, this block freezes PC and IF/ID and inserts exactly one
//   bubble. On the next cycle the load is in MEM, so forwarding covers it.
//   A taken branch/jump in EX (ex_flush) turns the next EX slot into a bubble.
//   A data-memory stall (mem_stall) freezes the whole front end.
//
//   Edge priority: rst > ex_flush > mem_stall > lu_hazard > normal load.
//   Once the FSM is in HOLD and mem_stall is still high, nothing changes
//   (a flush is not applied until the stall is released).
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_*                decoded instruction, operands and control from ID
//   ex_flush            branch/jump resolved taken in EX
//   mem_stall           data memory busy
//   ex_*                registered copies of id_* (ex_valid marks a real instr)
//   pc_write_en         0 = hold PC
//   if_id_write_en      0 = hold IF/ID register
//   fsm_state           debug view of the stall FSM (0 = RUN, 1 = HOLD)
//
// Configuration
//   ID_EX_PERF_CNT_EN   adds bubble_cnt / flush_cnt (32-bit, wrap, clear on rst)
//
// Handshake: there is no valid/ready pair here. ex_valid qualifies the EX
// slot; the write enables are combinational and take effect on the same edge.
// Control bits are alu_op, alu_src, mem_rd, mem_wr, reg_wr and mem_to_reg; a
// bubble clears them together with ex_valid so forwarding never matches it.

module id_ex_stage_reg #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alu_src,
  input  logic               id_mem_rd,
  input  logic               id_mem_wr,
  input  logic               id_reg_wr,
  input  logic               id_mem_to_reg,
  input  logic               ex_flush,
  input  logic               mem_stall,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [4:0]         ex_rd,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_mem_rd,
  output logic               ex_mem_wr,
  output logic               ex_reg_wr,
  output logic               ex_mem_to_reg,
  output logic               pc_write_en,
  output logic               if_id_write_en,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        flush_cnt,
`endif
  output logic               fsm_state
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t state, state_next;
  logic   lu_hazard;
  logic   frozen;     // HOLD with the stall still asserted: nothing moves
  logic   do_flush;
  logic   do_bubble;
  logic   do_load;

  assign fsm_state = state;

  // rd == 0 never hazards: x0 is never actually written.
  assign lu_hazard = ex_valid & ex_mem_rd & (ex_rd != 5'd0) & id_valid &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_next     = state;
    frozen         = 1'b0;
    do_flush       = 1'b0;
    do_bubble      = 1'b0;
    do_load        = 1'b0;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;

    case (state)
      RUN:     if (mem_stall) state_next = HOLD;
      HOLD: begin
        if (!mem_stall) state_next = RUN;
        frozen = mem_stall;
      end
      default: state_next = RUN;
    endcase

    if (frozen) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
    end else if (ex_flush) begin
      // Flush beats the hazard; the front end only holds if memory is busy.
      do_flush = 1'b1;
      if (mem_stall) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
      end
    end else if (mem_stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
    end else if (lu_hazard) begin
      do_bubble      = 1'b1;
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
    end else begin
      do_load = 1'b1;
    end

    if (rst) begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_reg_wr     <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (do_flush || do_bubble) begin
        // Bubble: data/index fields keep stale values, which is harmless
        // because valid and every control bit are cleared.
        ex_valid      <= 1'b0;
        ex_alu_op     <= '0;
        ex_alu_src    <= 1'b0;
        ex_mem_rd     <= 1'b0;
        ex_mem_wr     <= 1'b0;
        ex_reg_wr     <= 1'b0;
        ex_mem_to_reg <= 1'b0;
      end else if (do_load) begin
        ex_valid      <= id_valid;
        ex_pc         <= id_pc;
        ex_rs1        <= id_rs1;
        ex_rs2        <= id_rs2;
        ex_rd         <= id_rd;
        ex_rs1_data   <= id_rs1_data;
        ex_rs2_data   <= id_rs2_data;
        ex_imm        <= id_imm;
        ex_alu_op     <= id_valid ? id_alu_op : '0;
        ex_alu_src    <= id_valid & id_alu_src;
        ex_mem_rd     <= id_valid & id_mem_rd;
        ex_mem_wr     <= id_valid & id_mem_wr;
        ex_reg_wr     <= id_valid & id_reg_wr;
        ex_mem_to_reg <= id_valid & id_mem_to_reg;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (do_bubble) bubble_cnt <= bubble_cnt + 32'd1;
      if (do_flush)  flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus a random
// run, all compared against a behavioural model of the EX slot.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [3:0]  alu_op;
    logic        alu_src, mem_rd, mem_wr, reg_wr, mem_to_reg;
  } ex_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_mem_rd, id_mem_wr, id_reg_wr, id_mem_to_reg;
  logic        ex_flush, mem_stall;

  logic        ex_valid, ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_mem_to_reg;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        pc_write_en, if_id_write_en, fsm_state;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_rd(id_mem_rd),
    .id_mem_wr(id_mem_wr), .id_reg_wr(id_reg_wr), .id_mem_to_reg(id_mem_to_reg),
    .ex_flush(ex_flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .fsm_state(fsm_state)
  );

  ex_t act_ex;
  assign act_ex = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data,
                   ex_imm, ex_alu_op, ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr,
                   ex_mem_to_reg};

  // reference model of the EX slot
  ex_t         m;
  logic        m_hold;
  logic [31:0] m_bub, m_fl;
  logic [1:0]  exp_en, act_en;
  int          checks = 0;
  int          errors = 0;

  function automatic logic model_hazard();
    return m.valid && m.mem_rd && m.rd != 0 && id_valid &&
           ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
  endfunction

  // Front end may move unless: still frozen in a stall, memory busy now,
  // or a load-use hazard that no flush overrides. Reset forces it open.
  function automatic logic [1:0] model_en();
    logic open_fe;
    open_fe = !(m_hold && mem_stall) && !mem_stall && !(model_hazard() && !ex_flush);
    return (rst || open_fe) ? 2'b11 : 2'b00;
  endfunction

  function automatic void model_edge();
    logic hz;
    hz = model_hazard();
    if (rst) begin
      m = '0; m_hold = 1'b0; m_bub = 0; m_fl = 0;
    end else if (m_hold && mem_stall) begin
      // frozen: nothing changes
    end else begin
      if (ex_flush || (!mem_stall && hz)) begin
        m.valid = 1'b0; m.alu_op = '0; m.alu_src = 1'b0; m.mem_rd = 1'b0;
        m.mem_wr = 1'b0; m.reg_wr = 1'b0; m.mem_to_reg = 1'b0;
        if (ex_flush) m_fl = m_fl + 1; else m_bub = m_bub + 1;
      end else if (!mem_stall) begin
        m.valid = id_valid; m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
        m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm;
        m.alu_op     = id_valid ? id_alu_op : 4'd0;
        m.alu_src    = id_valid & id_alu_src;
        m.mem_rd     = id_valid & id_mem_rd;
        m.mem_wr     = id_valid & id_mem_wr;
        m.reg_wr     = id_valid & id_reg_wr;
        m.mem_to_reg = id_valid & id_mem_to_reg;
      end
      m_hold = mem_stall;
    end
  endfunction

  // Advance one clock: sample the comb enables mid-cycle, then update the model.
  task automatic tick();
    @(negedge clk);
    exp_en = model_en();
    act_en = {pc_write_en, if_id_write_en};
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // driver tasks
  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic use1, input logic use2, input logic mrd, input logic rwr);
    id_valid = 1'b1; id_pc = $urandom; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = use1; id_use_rs2 = use2;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_alu_op = 4'($urandom_range(0, 15)); id_alu_src = mrd;
    id_mem_rd = mrd; id_mem_wr = 1'b0; id_reg_wr = rwr; id_mem_to_reg = mrd;
  endtask

  task automatic rand_id();
    id_valid = ($urandom_range(0, 7) != 0);
    id_pc = $urandom; id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_alu_op = 4'($urandom_range(0, 15)); id_alu_src = 1'($urandom);
    id_mem_rd = 1'($urandom); id_mem_wr = 1'($urandom); id_reg_wr = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (act_en !== 2'b11) begin errors++; $display("FAIL reset_en: got %b exp 11", act_en); end
      checks++;
      if ({ex_valid, ex_reg_wr, ex_rd} !== 7'd0) begin
        errors++; $display("FAIL reset_ex: got valid=%b reg_wr=%b rd=%0d exp 0", ex_valid, ex_reg_wr, ex_rd);
      end
      checks++;
      if (act_ex !== m) begin errors++; $display("FAIL reset_all: got %h exp %h", act_ex, m); end
    end
    rst = 1'b0;
  endtask

  task automatic test_independent();
    logic [4:0] rds [2];
    rds[0] = 5'd3; rds[1] = 5'd4;
    for (int i = 0; i < 2; i++) begin
      set_instr(5'd1, 5'd2, rds[i], 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      checks++;
      if (act_en !== 2'b11) begin errors++; $display("FAIL indep_en: got %b exp 11", act_en); end
      checks++;
      if (act_ex !== m || ex_rd !== rds[i] || ex_valid !== 1'b1) begin
        errors++; $display("FAIL indep_ex: got %h exp %h", act_ex, m);
      end
    end
  endtask

  task automatic test_load_use();
    set_instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);   // LW x5
    tick();
    set_instr(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);   // ADD x6,x5,x1
    tick();
    checks++;
    if (act_en !== 2'b00) begin errors++; $display("FAIL lu_stall_en: got %b exp 00", act_en); end
    checks++;
    if (ex_valid !== 1'b0 || ex_mem_rd !== 1'b0 || ex_reg_wr !== 1'b0 || act_ex !== m) begin
      errors++; $display("FAIL lu_bubble: got %h exp %h", act_ex, m);
    end
    tick();                                                // ID still holds the ADD
    checks++;
    if (act_en !== 2'b11) begin errors++; $display("FAIL lu_resume_en: got %b exp 11", act_en); end
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6 || act_ex !== m) begin
      errors++; $display("FAIL lu_resume_ex: got %h exp %h", act_ex, m);
    end
  endtask

  task automatic test_no_hazard();
    set_instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);   // LW x0
    tick();
    set_instr(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);   // reads x0
    tick();
    checks++;
    if (act_en !== 2'b11 || act_ex !== m) begin
      errors++; $display("FAIL rd0_nostall: en got %b exp 11, ex got %h exp %h", act_en, act_ex, m);
    end
    set_instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);   // LW x5
    tick();
    set_instr(5'd1, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);   // rs2=5 but unused
    tick();
    checks++;
    if (act_en !== 2'b11 || ex_valid !== 1'b1 || act_ex !== m) begin
      errors++; $display("FAIL unused_rs2: en got %b exp 11, ex got %h exp %h", act_en, act_ex, m);
    end
  endtask

  task automatic test_flush_hazard();
    set_instr(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);   // LW x5
    tick();
    set_instr(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    checks++;
    if (act_en !== 2'b11) begin errors++; $display("FAIL flush_en: got %b exp 11", act_en); end
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_wr !== 1'b0 || act_ex !== m) begin
      errors++; $display("FAIL flush_ex: got %h exp %h", act_ex, m);
    end
  endtask

  task automatic test_mem_stall();
    ex_t snap;
    set_instr(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    snap = act_ex;
    set_instr(5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_en !== 2'b00) begin errors++; $display("FAIL stall_en: got %b exp 00", act_en); end
      checks++;
      if (act_ex !== snap || act_ex !== m) begin
        errors++; $display("FAIL stall_frozen: got %h exp %h", act_ex, m);
      end
    end
    mem_stall = 1'b0;
    tick();
    checks++;
    if (act_en !== 2'b11 || ex_rd !== 5'd10 || act_ex !== m) begin
      errors++; $display("FAIL stall_release: en %b ex %h exp %h", act_en, act_ex, m);
    end
    mem_stall = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (act_en !== 2'b11 || act_ex !== '0 || fsm_state !== 1'b0) begin
      errors++; $display("FAIL stall_reset: en %b ex %h state %b exp 11/0/0", act_en, act_ex, fsm_state);
    end
    rst = 1'b0; mem_stall = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rst       = ($urandom_range(0, 63) == 0);
      ex_flush  = ($urandom_range(0, 7) == 0);
      mem_stall = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (act_en !== exp_en) begin errors++; $display("FAIL rand_en[%0d]: got %b exp %b", i, act_en, exp_en); end
      checks++;
      if (act_ex !== m) begin errors++; $display("FAIL rand_ex[%0d]: got %h exp %h", i, act_ex, m); end
      checks++;
      if (fsm_state !== m_hold) begin
        errors++; $display("FAIL rand_state[%0d]: got %b exp %b", i, fsm_state, m_hold);
      end
    end
`ifdef ID_EX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== m_bub || flush_cnt !== m_fl) begin
      errors++; $display("FAIL perf_cnt: got %0d/%0d exp %0d/%0d", bubble_cnt, flush_cnt, m_bub, m_fl);
    end
`endif
    rst = 1'b0; ex_flush = 1'b0; mem_stall = 1'b0;
  endtask

  initial begin
    m = '0; m_hold = 1'b0; m_bub = 0; m_fl = 0;
    rst = 1'b1; ex_flush = 1'b0; mem_stall = 1'b0;
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_alu_op = '0; id_alu_src = 1'b0; id_mem_rd = 1'b0; id_mem_wr = 1'b0;
    id_reg_wr = 1'b0; id_mem_to_reg = 1'b0;
    test_reset();
    test_independent();
    test_load_use();
    test_no_hazard();
    test_flush_hazard();
    test_mem_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
